// File: rtl/muldiv_sequencer_if.sv
// Request/result and borrowed-ALU signals of the multiply/divide sequencer.
// The slave modport is the sequencer's view. The master modport is the view of the CPU and the ALU.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_r1;
  logic [WIDTH-1:0] alu_r2;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, op, a, b, alu_result,
    output busy, done, div_by_zero, hi, lo, alu_r1, alu_r2, alu_control
  );

  modport master (
    output start, op, a, b, alu_result,
    input  busy, done, div_by_zero, hi, lo, alu_r1, alu_r2, alu_control
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU engine that borrows an external single-cycle ALU for
// its add/subtract steps. Carries and compares are resolved locally, never taken from the ALU.
module muldiv_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_op;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_t;
  logic             w_ge;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_alu_r1;
  logic [WIDTH-1:0] w_alu_r2;
  logic [3:0]       w_alu_control;

  // A request is taken in IDLE and also in DONE, which allows back-to-back operations.
  assign w_accept   = bus.start && (r_state != S_BUSY);
  assign w_zero_div = bus.op && (bus.b == '0);
  assign w_last     = (r_cnt == '0);

  // Multiply step: the ALU result wraps, so a carry is present exactly when the sum comes out below hi.
  assign w_sum   = r_lo[0] ? bus.alu_result : r_hi;
  assign w_carry = r_lo[0] & (bus.alu_result < r_hi);

  // Divide step: a set hi MSB means the shifted remainder already exceeds any divisor.
  assign w_t  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_ge = r_hi[WIDTH-1] | (w_t >= r_opnd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = w_zero_div ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_state_next = w_zero_div ? S_DONE : S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_alu_r1      = '0;
    w_alu_r2      = '0;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_BUSY: begin
        w_busy   = 1'b1;
        w_alu_r2 = r_opnd;
        if (r_op) begin
          w_alu_r1      = w_t;
          w_alu_control = ALU_SUB;
        end else begin
          w_alu_r1      = r_hi;
          w_alu_control = ALU_ADD;
        end
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_op   <= 1'b0;
      r_dbz  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op  <= bus.op;
      r_cnt <= CW'(WIDTH - 1);
      r_dbz <= w_zero_div;
      if (!bus.op) begin
        r_hi   <= '0;
        r_lo   <= bus.b;
        r_opnd <= bus.a;
      end else if (w_zero_div) begin
        r_hi   <= bus.a;
        r_lo   <= '1;
        r_opnd <= bus.b;
      end else begin
        r_hi   <= '0;
        r_lo   <= bus.a;
        r_opnd <= bus.b;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      if (!r_op) begin
        {r_hi, r_lo} <= {w_carry, w_sum, r_lo[WIDTH-1:1]};
      end else begin
        r_hi <= w_ge ? bus.alu_result : w_t;
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.alu_r1      = w_alu_r1;
  assign bus.alu_r2      = w_alu_r2;
  assign bus.alu_control = w_alu_control;
endmodule
